// File: rtl/sp_mem_arbiter.sv
// rtl/sp_mem_arbiter.sv - shares one single-port data memory among SP cores; define SP_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module sp_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  localparam int ID_W   = $clog2(N_CORES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] we,
  input  logic [ADDR_W-1:0] addr  [N_CORES],
  input  logic [DATA_W-1:0] wdata [N_CORES],
  output logic [N_CORES-1:0] ack,
  output logic [DATA_W-1:0] rdata [N_CORES],
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t               state_q, state_d;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic                 lat_we_q, lat_we_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic [N_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q [N_CORES];
  logic [DATA_W-1:0]    rdata_d [N_CORES];
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;

`ifndef SP_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]      last_q, last_d;

  // Candidate index for the offs-th position of the search that starts just after base.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offs);
    return ID_W'((int'(base) + 1 + offs) % N_CORES);
  endfunction
`endif

  // Pick the winning requester: lowest index, or first after the last grant with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N_CORES; i++) begin
`ifdef SP_ARB_FIXED_PRIO_EN
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
`else
      if (!win_found && req[rr_index(last_q, i)]) begin
        win_found = 1'b1;
        win_id    = rr_index(last_q, i);
      end
`endif
    end
  end

  // Next state and next values of every registered output; grant is only taken in IDLE.
  always_comb begin
    state_d    = state_q;
    lat_we_d   = lat_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    grant_id_d = grant_id_q;
    rdata_d    = rdata_q;
    mem_we_d   = 1'b0;
    ack_d      = '0;
`ifndef SP_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && win_found) begin
      grant_id_d = win_id;
      lat_we_d   = we[win_id];
      mem_we_d   = we[win_id];
      mem_addr_d = addr[win_id];
      mem_data_d = wdata[win_id];
`ifndef SP_ARB_FIXED_PRIO_EN
      last_d     = win_id;
`endif
    end

    // Memory read data is valid during WAIT; capture it so it is visible with the ack.
    if (state_q == S_WAIT && !lat_we_q) rdata_d[grant_id_q] = mem_q;

    if (state_d == S_ACK) ack_d[grant_id_q] = 1'b1;
    mem_en_d = (state_d == S_ISSUE);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_we_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
      for (int i = 0; i < N_CORES; i++) rdata_q[i] <= '0;
`ifndef SP_ARB_FIXED_PRIO_EN
      last_q     <= ID_W'(N_CORES - 1);
`endif
    end else begin
      state_q    <= state_d;
      lat_we_q   <= lat_we_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
      rdata_q    <= rdata_d;
`ifndef SP_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb/tb_sp_mem_arbiter.sv - scoreboard bench for sp_mem_arbiter (both arbitration modes)
module tb_sp_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, ack;
  logic [AW-1:0]   addr  [N];
  logic [DW-1:0]   wdata [N];
  logic [DW-1:0]   rdata [N];
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [DW-1:0]   mem_q = '0;
  logic            busy;
  logic [1:0]      grant_id;

  typedef struct {
    int            core;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            ack_cyc[$];
  int            ack_core[$];
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] model_rd [N];
  logic [N-1:0]  hold_mask;
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            t0;

  sp_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_data;
      mem_q <= mem[mem_addr[7:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata_or();
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < N; i++) acc |= rdata[i];
    return acc;
  endfunction

  task automatic expect_core(input int core, input bit front);
    exp_t e;
    e.core = core;
    if (!we[core]) model_rd[core] = ref_mem[addr[core][7:0]];
    e.data = model_rd[core];
    if (front) sb.push_front(e);
    else sb.push_back(e);
  endtask

  task automatic post(input int core, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit front);
    we[core]    = w;
    addr[core]  = a;
    wdata[core] = d;
    req[core]   = 1'b1;
    expect_core(core, front);
    if (w) ref_mem[a[7:0]] = d;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && ack != '0) begin
      check_eq("ack_onehot", 32'($onehot(ack)), 1);
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_ack", 32'(ack), 0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_ack_core", 32'(ack), 32'(1) << e.core);
        check_eq("sb_grant_id", 32'(grant_id), e.core);
        check_eq("sb_rdata", 32'(rdata[e.core]), 32'(e.data));
      end
      ack_cyc.push_back(cyc);
      ack_core.push_back(int'(grant_id));
      req = req & ~(ack & ~hold_mask);
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && (sb.size() != 0 || busy); i++) step();
    check_eq("drain_done", 32'(sb.size() == 0 && !busy), 1);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < N; i++) model_rd[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req = '0;
    we = '0;
    hold_mask = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      model_rd[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mem[i]     = DW'(i * 16'h0101) ^ 16'h5a5a;
      ref_mem[i] = DW'(i * 16'h0101) ^ 16'h5a5a;
    end
    mem[8'h10] = 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;

    repeat (3) step();
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_mem_en", 32'(mem_en), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_mem_data", 32'(mem_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_grant_id", 32'(grant_id), 0);
    check_eq("rst_rdata", 32'(rdata_or()), 0);
    reset = 1'b0;

    // Single read by core 2.
    post(2, 1'b0, 16'h0010, 16'h0000, 1'b0);
    t0 = cyc;
    step();
    check_eq("rd_mem_en", 32'(mem_en), 1);
    check_eq("rd_mem_we", 32'(mem_we), 0);
    check_eq("rd_mem_addr", 32'(mem_addr), 32'h0010);
    check_eq("rd_busy", 32'(busy), 1);
    check_eq("rd_grant", 32'(grant_id), 2);
    step();
    check_eq("rd_wait_en", 32'(mem_en), 0);
    step();
    check_eq("rd_ack", 32'(ack), 32'h4);
    check_eq("rd_data", 32'(rdata[2]), 32'hBEEF);
    check_eq("rd_latency", cyc - t0, 3);
    step();
    check_eq("rd_idle_busy", 32'(busy), 0);
    check_eq("rd_ack_pulse", 32'(ack), 0);

    // Single write by core 1, then read it back.
    post(1, 1'b1, 16'h0004, 16'h1234, 1'b0);
    step();
    check_eq("wr_mem_en", 32'(mem_en), 1);
    check_eq("wr_mem_we", 32'(mem_we), 1);
    check_eq("wr_mem_addr", 32'(mem_addr), 32'h0004);
    check_eq("wr_mem_data", 32'(mem_data), 32'h1234);
    step();
    check_eq("wr_wait_we", 32'(mem_we), 0);
    step();
    check_eq("wr_ack", 32'(ack), 32'h2);
    check_eq("wr_rdata_kept", 32'(rdata[1]), 0);
    step();
    post(1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    drain(10);
    check_eq("wr_readback", 32'(rdata[1]), 32'h1234);

    // Contention from a fresh reset: all four request together.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < N; i++) post(i, 1'b0, AW'(16'h0020 + i), 16'h0000, 1'b0);
    t0 = cyc;
    ack_cyc.delete();
    ack_core.delete();
    drain(40);
    check_eq("cont_count", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) begin
      for (int i = 0; i < N; i++) begin
        check_eq("cont_order", ack_core[i], i);
        check_eq("cont_cycle", ack_cyc[i] - t0, 3 + 4 * i);
      end
    end

    // Fairness wrap: core 0 wins, then a fresh core 0 request loses to core 3 (round-robin).
    ack_core.delete();
    post(0, 1'b0, 16'h0030, 16'h0000, 1'b0);
    post(3, 1'b0, 16'h0033, 16'h0000, 1'b0);
    for (int i = 0; i < 20 && ack_core.size() == 0; i++) step();
    check_eq("fair_first_seen", ack_core.size(), 1);
    if (ack_core.size() == 1) check_eq("fair_first_core", ack_core[0], 0);
`ifdef SP_ARB_FIXED_PRIO_EN
    post(0, 1'b0, 16'h0031, 16'h0000, 1'b1);
`else
    post(0, 1'b0, 16'h0031, 16'h0000, 1'b0);
`endif
    drain(20);
    check_eq("fair_count", ack_core.size(), 3);

    // Reset during WAIT aborts the transaction.
    post(2, 1'b0, 16'h0010, 16'h0000, 1'b0);
    step();
    step();
    check_eq("abort_wait_busy", 32'(busy), 1);
    check_eq("abort_wait_en", 32'(mem_en), 0);
    reset = 1'b1;
    req = '0;
    step();
    check_eq("abort_ack", 32'(ack), 0);
    check_eq("abort_mem_en", 32'(mem_en), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_rdata", 32'(rdata_or()), 0);
    reset = 1'b0;
    clear_model();
    step();
    check_eq("abort_no_ack", 32'(ack), 0);
    check_eq("abort_no_en", 32'(mem_en), 0);
    ack_cyc.delete();
    post(2, 1'b0, 16'h0010, 16'h0000, 1'b0);
    t0 = cyc;
    drain(10);
    check_eq("abort_recover_cnt", ack_cyc.size(), 1);
    if (ack_cyc.size() == 1) check_eq("abort_recover_lat", ack_cyc[0] - t0, 3);

    // Cores 1 and 3 request continuously.
    ack_cyc.delete();
    ack_core.delete();
    hold_mask = 4'b1010;
    we[1] = 1'b0;
    we[3] = 1'b0;
    addr[1] = 16'h0041;
    addr[3] = 16'h0043;
    req[1] = 1'b1;
    req[3] = 1'b1;
`ifdef SP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) expect_core(1, 1'b0);
`else
    expect_core(3, 1'b0);
    expect_core(1, 1'b0);
    expect_core(3, 1'b0);
`endif
    for (int i = 0; i < 30 && ack_cyc.size() < 3; i++) step();
    check_eq("cont_req_acks", ack_cyc.size(), 3);
    if (ack_cyc.size() == 3) begin
      check_eq("cont_req_gap0", ack_cyc[1] - ack_cyc[0], 4);
      check_eq("cont_req_gap1", ack_cyc[2] - ack_cyc[1], 4);
    end
`ifdef SP_ARB_FIXED_PRIO_EN
    req[1] = 1'b0;
    expect_core(3, 1'b0);
`else
    req = '0;
`endif
    hold_mask = '0;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sp_mem_arbiter.md
# sp_mem_arbiter

Round-robin arbiter that shares one synchronous single-port data memory among the N SP cores of an SM. Each core presents an independent request (address, write data, write enable). The arbiter serialises requests onto the shared memory port one at a time, captures read data, and returns it with a one-cycle acknowledge to the requesting core. It sits between the SP-core array's per-core memory ports and the SM's data memory.

## Interface
Parameters:
- N_CORES, 4, number of requesting SP cores (2..16)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_CORES  per-core request; held high until that core's ack
- we  in  N_CORES  per-core write enable (1 = write, 0 = read); stable while req high
- addr  in  ADDR_W x N_CORES (unpacked)  per-core address; stable while req high
- wdata  in  DATA_W x N_CORES (unpacked)  per-core write data; stable while req high
- ack  out  N_CORES  one-cycle completion pulse to the granted core
- rdata  out  DATA_W x N_CORES (unpacked)  per-core registered read data
- mem_en  out  1  shared memory access strobe
- mem_we  out  1  shared memory write strobe
- mem_addr  out  ADDR_W  shared memory address
- mem_data  out  DATA_W  shared memory write data
- mem_q  in  DATA_W  shared memory read data, valid 1 cycle after mem_en
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(N_CORES)  index of the current or most recent granted core

## Operation
- FSM states are IDLE, ISSUE, WAIT and ACK, with transitions IDLE→ISSUE (any req high), ISSUE→WAIT, WAIT→ACK, ACK→IDLE. IDLE holds when no req.
- Arbitration happens only in IDLE.
  - The winner is the first core with req high, searching from index (last+1) mod N_CORES upward with wrap.
  - `last` updates to the winner on the IDLE→ISSUE edge.
  - Reset value of `last` is N_CORES-1, so core 0 has top priority after reset.
- Winner's we/addr/wdata are registered on the IDLE→ISSUE edge. Later changes to those inputs are ignored.
- ISSUE: mem_en=1; mem_we=latched we; mem_addr and mem_data are driven from the latched values.
- WAIT: mem_en=0 and mem_we=0. On a read, mem_q is captured into rdata[grant_id] at the end of WAIT.
- ACK: ack[grant_id]=1 for exactly this cycle. rdata[grant_id] is valid from this cycle and holds until the next read by that core.
  - For writes, rdata is unchanged.
- A requester must drop req in the cycle after ack, unless it issues a new request. A req still high in IDLE is treated as a new request.
- Non-granted requests wait. They are never dropped or reordered within a core.
- Reset values:
  - state=IDLE
  - ack=0, mem_en=0, mem_we=0
  - mem_addr=0, mem_data=0
  - all rdata=0
  - grant_id=0, busy=0
- Reset in any state aborts the in-flight transaction: no ack is issued and no further memory strobe is driven.

## Timing
- All outputs are registered. No combinational path exists from req/addr/wdata/mem_q to outputs.
- Single transaction:
  - req high in cycle T (state IDLE)
  - mem_en in T+1
  - mem_q sampled at end of T+2
  - ack and rdata valid in T+3
  - IDLE in T+4
- Req-to-ack latency is 3 cycles. Throughput is one transaction per 4 cycles.
- With all N cores requesting continuously, each core is served once every 4·N_CORES cycles. This bounds starvation.
- Simultaneous req from several cores in the same IDLE cycle: exactly one grant, decided by the round-robin order.
- A req asserted while busy is not seen until the next IDLE.

## Configuration
- SP_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index requesting core always wins, and `last` is unused.
  - Undefined (default): round-robin as described above.
  - Interface and timing are identical in both modes.

## Test plan
- Single read: core 2 requests addr=0x0010 with memory[0x0010]=0xBEEF at T=10 → mem_en and mem_addr=0x0010 at 11; ack[2] and rdata[2]=0xBEEF at 13; busy low at 14.
- Single write: core 1 requests we=1, addr=0x0004, wdata=0x1234 → mem_we=1 with mem_data=0x1234 at T+1; ack[1] at T+3; rdata[1] unchanged; a subsequent read of 0x0004 returns 0x1234.
- Contention: all 4 cores request at cycle 0 after reset, each dropping req after its ack → acks in order core 0,1,2,3 at cycles 3,7,11,15.
- Fairness wrap: after core 3 is served, cores 0 and 3 request together → core 0 granted first; then core 0 re-requests together with core 3 → core 3 wins.
- Reset mid-operation: reset asserted in the WAIT cycle → next cycle shows state IDLE, no ack, mem_en=0, all rdata=0; a core 2 request issued after reset completes normally.
- SP_ARB_FIXED_PRIO_EN defined: cores 1 and 3 request continuously → core 1 acked every 4 cycles and core 3 never, until core 1 drops req.
